// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, runs a req/ack imem port with arbitrary
// latency, and writes the IF/ID register under hazard-unit stall and ID redirect.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rstN,
    input  logic        pcLd,
    input  logic        IFtoIDwrite,
    input  logic        redirect,
    input  logic [31:0] redirectAddr,
    output logic        imemReq,
    output logic [31:0] imemAddr,
    input  logic        imemAck,
    input  logic [31:0] imemData,
    output logic [31:0] IFtoIDinst,
    output logic [31:0] IFtoIDpcPlus4,
    output logic        IFtoIDvalid
);

    typedef enum logic [1:0] {
        S_FETCH   = 2'd0,
        S_HOLD    = 2'd1,
        S_DISCARD = 2'd2
    } state_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] inst;
        logic [31:0] pc_plus4;
    } ifid_t;

    localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] hold_inst_q, hold_inst_d;
    logic [31:0] pend_target_q, pend_target_d;
    ifid_t       ifid_q, ifid_d;

    logic        advance;
    logic [31:0] target;
    logic [31:0] pc_plus4;
    logic        deliver;
    logic [31:0] deliver_inst;

    assign advance  = pcLd & IFtoIDwrite;
    assign target   = {redirectAddr[31:2], 2'b00};
    assign pc_plus4 = pc_q + 32'd4;

    // Request depends only on state and PC; reset gating keeps the port quiet
    // while the memory is held in reset alongside us.
    assign imemReq  = rstN && (state_q != S_HOLD);
    assign imemAddr = pc_q;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        hold_inst_d   = hold_inst_q;
        pend_target_d = pend_target_q;
        deliver       = 1'b0;
        deliver_inst  = 32'h0;

        unique case (state_q)
            S_FETCH: begin
                if (imemAck) begin
                    if (redirect) begin
                        pc_d = target;
                    end else if (advance) begin
                        deliver      = 1'b1;
                        deliver_inst = imemData;
                        pc_d         = pc_plus4;
                    end else begin
                        hold_inst_d = imemData;
                        state_d     = S_HOLD;
                    end
                end else if (redirect) begin
                    // Address must stay put until the old request completes.
                    pend_target_d = target;
                    state_d       = S_DISCARD;
                end
            end
            S_HOLD: begin
                if (redirect) begin
                    pc_d    = target;
                    state_d = S_FETCH;
                end else if (advance) begin
                    deliver      = 1'b1;
                    deliver_inst = hold_inst_q;
                    pc_d         = pc_plus4;
                    state_d      = S_FETCH;
                end
            end
            S_DISCARD: begin
                if (redirect) pend_target_d = target;
                if (imemAck) begin
                    pc_d    = redirect ? target : pend_target_q;
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_FETCH;
        endcase
    end

    always_comb begin
        ifid_d = '0;
        if (redirect) begin
            ifid_d = '0;
        end else if (!IFtoIDwrite) begin
            ifid_d = ifid_q;
        end else if (deliver) begin
            ifid_d = '{valid: 1'b1, inst: deliver_inst, pc_plus4: pc_plus4};
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q       <= S_FETCH;
            pc_q          <= RESET_PC_ALIGNED;
            hold_inst_q   <= 32'h0;
            pend_target_q <= 32'h0;
            ifid_q        <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            hold_inst_q   <= hold_inst_d;
            pend_target_q <= pend_target_d;
            ifid_q        <= ifid_d;
        end
    end

    assign IFtoIDinst    = ifid_q.inst;
    assign IFtoIDpcPlus4 = ifid_q.pc_plus4;
    assign IFtoIDvalid   = ifid_q.valid;

endmodule

// File: tb/tb_fetch_unit.sv
// Scenario bench for fetch_unit: a latency-programmable memory model feeds the
// DUT, and expected IF/ID contents are queued per cycle and popped after each edge.
module tb_fetch_unit;

    localparam logic [31:0] RPC = 32'h0040_0000;

    typedef struct packed {
        logic        v;
        logic [31:0] inst;
        logic [31:0] pc4;
    } ifid_t;

    logic        clk = 1'b0;
    logic        rstN;
    logic        pcLd, IFtoIDwrite, redirect;
    logic [31:0] redirectAddr;
    logic        imemReq, imemAck;
    logic [31:0] imemAddr, imemData;
    logic [31:0] IFtoIDinst, IFtoIDpcPlus4;
    logic        IFtoIDvalid;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          lat     = 0;
    int          wait_cnt;
    ifid_t       exp_q[$];
    ifid_t       obs, exp_e;

    fetch_unit #(.RESET_PC(RPC)) dut (
        .clk(clk), .rstN(rstN), .pcLd(pcLd), .IFtoIDwrite(IFtoIDwrite),
        .redirect(redirect), .redirectAddr(redirectAddr),
        .imemReq(imemReq), .imemAddr(imemAddr), .imemAck(imemAck), .imemData(imemData),
        .IFtoIDinst(IFtoIDinst), .IFtoIDpcPlus4(IFtoIDpcPlus4), .IFtoIDvalid(IFtoIDvalid)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'h1234, a[31:16] ^ 16'hA5C3};
    endfunction

    function automatic ifid_t ent(input logic [31:0] a);
        return '{v: 1'b1, inst: mem_word(a), pc4: a + 32'd4};
    endfunction

    // Memory: acks after `lat` wait cycles on a continuously held request.
    assign imemAck  = imemReq && (wait_cnt >= lat);
    assign imemData = imemAck ? mem_word(imemAddr) : 32'hDEAD_BEEF;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN)                   wait_cnt <= 0;
        else if (!imemReq || imemAck) wait_cnt <= 0;
        else                         wait_cnt <= wait_cnt + 1;
    end

    task automatic drive(input logic pl, input logic iw, input logic rd, input logic [31:0] ra);
        pcLd = pl; IFtoIDwrite = iw; redirect = rd; redirectAddr = ra;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        obs = '{v: IFtoIDvalid, inst: IFtoIDinst, pc4: IFtoIDpcPlus4};
        exp_e = exp_q.pop_front();
    endtask

    task automatic test_reset();
        rstN = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 32'h0);
        n_tests++;
        if (imemReq !== 1'b0 || IFtoIDvalid !== 1'b0 || IFtoIDinst !== 32'h0 || IFtoIDpcPlus4 !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_out: req=%b v=%b inst=%h pc4=%h, want all 0", imemReq, IFtoIDvalid, IFtoIDinst, IFtoIDpcPlus4);
        end
        @(posedge clk); @(posedge clk); #1;
        rstN = 1'b1;
        #1;
        n_tests++;
        if (imemReq !== 1'b1 || imemAddr !== RPC) begin
            n_fail++;
            $display("FAIL reset_first_req: req=%b addr=%h, want 1 %h", imemReq, imemAddr, RPC);
        end
    endtask

    task automatic test_zero_wait();
        lat = 0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 1'b0, 32'h0);
            n_tests++;
            if (imemReq !== 1'b1 || imemAddr !== RPC + 32'(4 * i)) begin
                n_fail++;
                $display("FAIL zw_addr%0d: req=%b addr=%h, want 1 %h", i, imemReq, imemAddr, RPC + 32'(4 * i));
            end
            exp_q.push_back(ent(RPC + 32'(4 * i)));
            step();
            n_tests++;
            if (obs !== exp_e) begin
                n_fail++;
                $display("FAIL zw_ifid%0d: got %h, want %h", i, obs, exp_e);
            end
        end
    endtask

    // Stall lands on the ack of 0x..0C; IF/ID keeps the 0x..08 entry meanwhile.
    task automatic test_stall();
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 1'b0, 1'b0, 32'h0);
            n_tests++;
            if (imemReq !== (i == 0)) begin
                n_fail++;
                $display("FAIL stall_req%0d: req=%b, want %b", i, imemReq, (i == 0));
            end
            exp_q.push_back(ent(RPC + 32'h8));
            step();
            n_tests++;
            if (obs !== exp_e) begin
                n_fail++;
                $display("FAIL stall_hold%0d: got %h, want %h", i, obs, exp_e);
            end
        end
        drive(1'b1, 1'b1, 1'b0, 32'h0);
        n_tests++;
        if (imemReq !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_release_req: req=%b, want 0", imemReq);
        end
        exp_q.push_back(ent(RPC + 32'hC));
        step();
        n_tests++;
        if (obs !== exp_e) begin
            n_fail++;
            $display("FAIL stall_release_ifid: got %h, want %h", obs, exp_e);
        end
        #1;
        n_tests++;
        if (imemReq !== 1'b1 || imemAddr !== RPC + 32'h10) begin
            n_fail++;
            $display("FAIL stall_no_refetch: req=%b addr=%h, want 1 %h", imemReq, imemAddr, RPC + 32'h10);
        end
    endtask

    task automatic test_latency_redirect();
        lat = 3;
        for (int c = 0; c < 4; c++) begin
            drive(1'b1, 1'b1, (c == 2), RPC + 32'h100);
            n_tests++;
            if (imemReq !== 1'b1 || imemAddr !== RPC + 32'h10) begin
                n_fail++;
                $display("FAIL lat_addr%0d: req=%b addr=%h, want 1 %h", c, imemReq, imemAddr, RPC + 32'h10);
            end
            exp_q.push_back('0);
            step();
            n_tests++;
            if (obs !== exp_e) begin
                n_fail++;
                $display("FAIL lat_bubble%0d: got %h, want %h", c, obs, exp_e);
            end
        end
        lat = 0;
        drive(1'b1, 1'b1, 1'b0, 32'h0);
        n_tests++;
        if (imemReq !== 1'b1 || imemAddr !== RPC + 32'h100) begin
            n_fail++;
            $display("FAIL lat_target: req=%b addr=%h, want 1 %h", imemReq, imemAddr, RPC + 32'h100);
        end
        exp_q.push_back(ent(RPC + 32'h100));
        step();
        n_tests++;
        if (obs !== exp_e) begin
            n_fail++;
            $display("FAIL lat_target_ifid: got %h, want %h", obs, exp_e);
        end
    endtask

    // Redirect + stall + ack together; low target bits must be ignored.
    task automatic test_redirect_stall_ack();
        drive(1'b0, 1'b0, 1'b1, RPC + 32'h203);
        exp_q.push_back('0);
        step();
        n_tests++;
        if (obs !== exp_e) begin
            n_fail++;
            $display("FAIL rsa_flush: got %h, want %h", obs, exp_e);
        end
        drive(1'b1, 1'b1, 1'b0, 32'h0);
        n_tests++;
        if (imemReq !== 1'b1 || imemAddr !== RPC + 32'h200) begin
            n_fail++;
            $display("FAIL rsa_no_hold: req=%b addr=%h, want 1 %h", imemReq, imemAddr, RPC + 32'h200);
        end
        exp_q.push_back(ent(RPC + 32'h200));
        step();
        n_tests++;
        if (obs !== exp_e) begin
            n_fail++;
            $display("FAIL rsa_target_ifid: got %h, want %h", obs, exp_e);
        end
    endtask

    task automatic test_wrap();
        drive(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC);
        exp_q.push_back('0);
        step();
        n_tests++;
        if (obs !== exp_e) begin
            n_fail++;
            $display("FAIL wrap_flush: got %h, want %h", obs, exp_e);
        end
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b1, 1'b0, 32'h0);
            n_tests++;
            if (imemAddr !== 32'hFFFF_FFFC + 32'(4 * i)) begin
                n_fail++;
                $display("FAIL wrap_addr%0d: addr=%h, want %h", i, imemAddr, 32'hFFFF_FFFC + 32'(4 * i));
            end
            exp_q.push_back(ent(32'hFFFF_FFFC + 32'(4 * i)));
            step();
            n_tests++;
            if (obs !== exp_e) begin
                n_fail++;
                $display("FAIL wrap_ifid%0d: got %h, want %h", i, obs, exp_e);
            end
        end
    endtask

    // Redirect while a stalled word sits in HOLD drops it.
    task automatic test_hold_redirect();
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        exp_q.push_back(ent(32'h0));
        step();
        n_tests++;
        if (obs !== exp_e || imemReq !== 1'b0) begin
            n_fail++;
            $display("FAIL hr_hold: got %h req=%b, want %h req=0", obs, imemReq, exp_e);
        end
        drive(1'b0, 1'b0, 1'b1, RPC + 32'h300);
        exp_q.push_back('0);
        step();
        n_tests++;
        if (obs !== exp_e) begin
            n_fail++;
            $display("FAIL hr_flush: got %h, want %h", obs, exp_e);
        end
        drive(1'b1, 1'b1, 1'b0, 32'h0);
        n_tests++;
        if (imemReq !== 1'b1 || imemAddr !== RPC + 32'h300) begin
            n_fail++;
            $display("FAIL hr_target: req=%b addr=%h, want 1 %h", imemReq, imemAddr, RPC + 32'h300);
        end
        exp_q.push_back(ent(RPC + 32'h300));
        step();
        n_tests++;
        if (obs !== exp_e) begin
            n_fail++;
            $display("FAIL hr_target_ifid: got %h, want %h", obs, exp_e);
        end
    endtask

    task automatic test_reset_mid_discard();
        lat = 3;
        drive(1'b1, 1'b1, 1'b1, RPC + 32'h500);
        exp_q.push_back('0);
        step();
        n_tests++;
        if (obs !== exp_e || imemAddr !== RPC + 32'h304) begin
            n_fail++;
            $display("FAIL rd_discard: got %h addr=%h, want %h addr=%h", obs, imemAddr, exp_e, RPC + 32'h304);
        end
        drive(1'b1, 1'b1, 1'b0, 32'h0);
        rstN = 1'b0;
        #1;
        n_tests++;
        if (imemReq !== 1'b0 || IFtoIDvalid !== 1'b0 || IFtoIDinst !== 32'h0 || IFtoIDpcPlus4 !== 32'h0) begin
            n_fail++;
            $display("FAIL rd_async: req=%b v=%b inst=%h pc4=%h, want all 0", imemReq, IFtoIDvalid, IFtoIDinst, IFtoIDpcPlus4);
        end
        @(posedge clk); #2;
        lat  = 0;
        rstN = 1'b1;
        #1;
        n_tests++;
        if (imemReq !== 1'b1 || imemAddr !== RPC) begin
            n_fail++;
            $display("FAIL rd_restart: req=%b addr=%h, want 1 %h", imemReq, imemAddr, RPC);
        end
        exp_q.push_back(ent(RPC));
        step();
        #1;
        n_tests++;
        if (obs !== exp_e || imemAddr !== RPC + 32'h4) begin
            n_fail++;
            $display("FAIL rd_after: got %h addr=%h, want %h addr=%h", obs, imemAddr, exp_e, RPC + 32'h4);
        end
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_stall();
        test_latency_redirect();
        test_redirect_stall_ack();
        test_wrap();
        test_hold_redirect();
        test_reset_mid_discard();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: sim time %0t, want completion before 20000", $time);
        $fatal(1);
    end

endmodule
